// File: rtl/l3_cache_ctrl.sv
// Voxel world cache controller: loads the world from a UART byte stream, then applies
// 3-byte update packets and arbitrates two read requesters onto one cache port.
module l3_cache_ctrl #(
    parameter int LENGTH     = 64,
    parameter int WIDTH      = 64,
    parameter int HEIGHT     = 16,
    parameter int RD_LATENCY = 2,
    localparam int XW = $clog2(LENGTH),
    localparam int YW = $clog2(WIDTH),
    localparam int ZW = $clog2(HEIGHT),
    localparam int AW = XW + YW + ZW
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic [7:0]    uart_data_in,
    input  logic          uart_valid_in,
    input  logic [1:0]    rd_req_in,
    input  logic [XW-1:0] rd0_x_in,
    input  logic [YW-1:0] rd0_y_in,
    input  logic [ZW-1:0] rd0_z_in,
    input  logic [XW-1:0] rd1_x_in,
    input  logic [YW-1:0] rd1_y_in,
    input  logic [ZW-1:0] rd1_z_in,
    output logic [1:0]    rd_grant_out,
    output logic [1:0]    rd_valid_out,
    output logic [7:0]    rd_data_out,
    output logic [AW-1:0] cache_addr_out,
    output logic [7:0]    cache_wdata_out,
    output logic          cache_we_out,
    output logic          cache_re_out,
    input  logic [7:0]    cache_rdata_in,
    output logic          initialized_out,
    output logic [AW-1:0] fill_count_out
);

    typedef enum logic [1:0] {S_FILL, S_UPD_HI, S_UPD_LO, S_UPD_DATA} state_t;

    state_t        r_state, w_state_nxt;
    logic [AW-1:0] r_fill_cnt, w_fill_nxt;
    logic [AW-1:0] r_upd_addr, w_upd_nxt;
    logic          r_wr_pend, w_wr_set;
    logic [AW-1:0] r_wr_addr, w_wr_addr_nxt;
    logic [7:0]    r_wr_data, w_wr_data_nxt;
    logic          r_init;
    logic          r_last;
    logic [AW-1:0] r_addr_hold;
    logic [RD_LATENCY-1:0][1:0] r_tag;

    logic          w_rd_ok;
    logic [1:0]    w_grant;
    logic [AW-1:0] w_rd_addr;
    logic [AW-1:0] w_addr;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The final load byte moves the FSM on as its write issues, so a byte arriving
    // right behind it is already treated as the start of an update packet.
    always_comb begin
        w_state_nxt   = r_state;
        w_fill_nxt    = r_fill_cnt;
        w_upd_nxt     = r_upd_addr;
        w_wr_set      = 1'b0;
        w_wr_addr_nxt = r_wr_addr;
        w_wr_data_nxt = r_wr_data;
        if (uart_valid_in) begin
            case (r_state)
                S_FILL: begin
                    w_wr_set      = 1'b1;
                    w_wr_addr_nxt = r_fill_cnt;
                    w_wr_data_nxt = uart_data_in;
                    w_fill_nxt    = r_fill_cnt + AW'(1);
                    if (&r_fill_cnt) w_state_nxt = S_UPD_HI;
                end
                S_UPD_HI: begin
                    w_upd_nxt   = (AW'(uart_data_in) << 8) | (r_upd_addr & AW'(8'hFF));
                    w_state_nxt = S_UPD_LO;
                end
                S_UPD_LO: begin
                    w_upd_nxt[7:0] = uart_data_in;
                    w_state_nxt    = S_UPD_DATA;
                end
                S_UPD_DATA: begin
                    w_wr_set      = 1'b1;
                    w_wr_addr_nxt = r_upd_addr;
                    w_wr_data_nxt = uart_data_in;
                    w_state_nxt   = S_UPD_HI;
                end
                default: w_state_nxt = S_FILL;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_fill_cnt <= '0;
            r_upd_addr <= '0;
            r_wr_pend  <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_init     <= 1'b0;
        end else begin
            r_fill_cnt <= w_fill_nxt;
            r_upd_addr <= w_upd_nxt;
            r_wr_pend  <= w_wr_set;
            r_wr_addr  <= w_wr_addr_nxt;
            r_wr_data  <= w_wr_data_nxt;
            // Only the last load write can reach the top address before init.
            r_init     <= r_init | (r_wr_pend & (&r_wr_addr));
        end
    end

    assign w_rd_ok = r_init & ~r_wr_pend;

    always_comb begin
        w_grant = 2'b00;
        if (w_rd_ok) begin
            case (rd_req_in)
                2'b01:   w_grant = 2'b01;
                2'b10:   w_grant = 2'b10;
                2'b11:   w_grant = r_last ? 2'b01 : 2'b10;
                default: w_grant = 2'b00;
            endcase
        end
    end

    assign w_rd_addr = w_grant[1] ? {rd1_z_in, rd1_y_in, rd1_x_in}
                                  : {rd0_z_in, rd0_y_in, rd0_x_in};
    assign w_addr    = r_wr_pend  ? r_wr_addr
                     : |w_grant   ? w_rd_addr
                     :              r_addr_hold;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_last      <= 1'b1;
            r_addr_hold <= '0;
            r_tag       <= '0;
        end else begin
            if (|w_grant) r_last <= w_grant[1];
            r_addr_hold <= w_addr;
            r_tag[0]    <= w_grant;
            for (int i = 1; i < RD_LATENCY; i++) r_tag[i] <= r_tag[i-1];
        end
    end

    assign rd_grant_out    = w_grant;
    assign rd_valid_out    = r_tag[RD_LATENCY-1];
    assign rd_data_out     = |rd_valid_out ? cache_rdata_in : 8'h00;
    assign cache_addr_out  = w_addr;
    assign cache_wdata_out = r_wr_data;
    assign cache_we_out    = r_wr_pend;
    assign cache_re_out    = |w_grant;
    assign initialized_out = r_init;
    assign fill_count_out  = r_fill_cnt;

endmodule

// File: tb/tb_l3_cache_ctrl.sv
// Bench for l3_cache_ctrl: emulated cache RAM, world-level reference model, directed
// scenarios followed by randomized update packets and read traffic.
module tb_l3_cache_ctrl;
    localparam int AW = 16;
    localparam int NB = 1 << AW;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic [7:0] uart_data_in = '0;
    logic       uart_valid_in = 1'b0;
    logic [1:0] rd_req_in = '0;
    logic [5:0] rd0_x_in = '0, rd1_x_in = '0;
    logic [5:0] rd0_y_in = '0, rd1_y_in = '0;
    logic [3:0] rd0_z_in = '0, rd1_z_in = '0;
    logic [1:0] rd_grant_out, rd_valid_out;
    logic [7:0] rd_data_out, cache_wdata_out, cache_rdata_in;
    logic [AW-1:0] cache_addr_out, fill_count_out;
    logic       cache_we_out, cache_re_out, initialized_out;

    always #5 clk_in = ~clk_in;

    l3_cache_ctrl dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .uart_data_in(uart_data_in), .uart_valid_in(uart_valid_in),
        .rd_req_in(rd_req_in),
        .rd0_x_in(rd0_x_in), .rd0_y_in(rd0_y_in), .rd0_z_in(rd0_z_in),
        .rd1_x_in(rd1_x_in), .rd1_y_in(rd1_y_in), .rd1_z_in(rd1_z_in),
        .rd_grant_out(rd_grant_out), .rd_valid_out(rd_valid_out), .rd_data_out(rd_data_out),
        .cache_addr_out(cache_addr_out), .cache_wdata_out(cache_wdata_out),
        .cache_we_out(cache_we_out), .cache_re_out(cache_re_out),
        .cache_rdata_in(cache_rdata_in),
        .initialized_out(initialized_out), .fill_count_out(fill_count_out)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    // Cache RAM with a two-cycle read latency.
    logic [7:0] cmem [0:NB-1];
    logic [7:0] rp0 = '0, rp1 = '0;
    always @(posedge clk_in) begin
        if (cache_we_out) cmem[cache_addr_out] <= cache_wdata_out;
        rp0 <= cache_re_out ? cmem[cache_addr_out] : 8'h00;
        rp1 <= rp0;
    end
    assign cache_rdata_in = rp1;

    // Reference model: world contents plus expected write/grant/response per cycle.
    typedef struct { int due; int who; int data; } rsp_t;
    rsp_t       rq[$];
    logic [7:0] ref_mem [0:NB-1];
    int cyc = 0, m_cnt, m_phase, m_upd, m_wa, m_wd, m_last, m_hold, eg, ea;
    bit m_init, m_wr;
    logic [1:0] g_prev = '0;

    always @(negedge clk_in) begin
        cyc++;
        g_prev = rd_grant_out;
        if (rst_in) begin
            chk("rst_we", cache_we_out, 0);
            chk("rst_re", cache_re_out, 0);
            chk("rst_gnt", rd_grant_out, 0);
            chk("rst_vld", rd_valid_out, 0);
            chk("rst_init", initialized_out, 0);
            chk("rst_fill", fill_count_out, 0);
            m_cnt = 0; m_phase = 0; m_upd = 0; m_wa = 0; m_wd = 0;
            m_last = 1; m_hold = 0; m_init = 0; m_wr = 0;
            rq.delete();
        end else begin
            chk("fill_cnt", fill_count_out, m_cnt % NB);
            chk("init", initialized_out, m_init);
            chk("we", cache_we_out, m_wr);
            if (m_wr) begin
                chk("waddr", cache_addr_out, m_wa);
                chk("wdata", cache_wdata_out, m_wd);
            end
            eg = 0;
            if (m_init && !m_wr)
                eg = (rd_req_in == 2'b11) ? (m_last == 1 ? 1 : 2) : int'(rd_req_in);
            chk("gnt", rd_grant_out, eg);
            chk("re", cache_re_out, eg != 0);
            if (eg != 0) begin
                ea = (eg == 2) ? rd1_z_in * 4096 + rd1_y_in * 64 + rd1_x_in
                               : rd0_z_in * 4096 + rd0_y_in * 64 + rd0_x_in;
                chk("raddr", cache_addr_out, ea);
                rq.push_back('{cyc + 2, eg, ref_mem[ea]});
                m_last = (eg == 2) ? 1 : 0;
                m_hold = ea;
            end else if (!m_wr) begin
                chk("ahold", cache_addr_out, m_hold);
            end
            if (rq.size() > 0 && rq[0].due == cyc) begin
                chk("vld", rd_valid_out, rq[0].who);
                chk("rdata", rd_data_out, rq[0].data);
                void'(rq.pop_front());
            end else begin
                chk("vld", rd_valid_out, 0);
            end
            if (m_wr) begin
                ref_mem[m_wa] = 8'(m_wd);
                m_hold = m_wa;
                if (m_wa == NB - 1) m_init = 1;
            end
            m_wr = 0;
            if (uart_valid_in) begin
                if (m_cnt < NB) begin
                    m_wr = 1; m_wa = m_cnt; m_wd = uart_data_in; m_cnt++;
                end else if (m_phase == 0) begin
                    m_upd = uart_data_in * 256; m_phase = 1;
                end else if (m_phase == 1) begin
                    m_upd = m_upd + uart_data_in; m_phase = 2;
                end else begin
                    m_wr = 1; m_wa = m_upd; m_wd = uart_data_in; m_phase = 0;
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk_in); #1;
    endtask

    task automatic send(input logic [7:0] b);
        uart_valid_in = 1'b1; uart_data_in = b;
        tick();
        uart_valid_in = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(); tick();
        chk("reset_init", initialized_out, 0);
        chk("reset_fill", fill_count_out, 0);
        chk("reset_addr", cache_addr_out, 0);
        rst_in = 1'b0;

        // Partial load interrupted by an asynchronous reset.
        rd_req_in = 2'b11;
        for (int i = 0; i < 100; i++) send(8'(i));
        chk("fc100", fill_count_out, 100);
        chk("fc100_we", cache_we_out, 1);
        #2 rst_in = 1'b1;
        #1;
        chk("arst_we", cache_we_out, 0);
        chk("arst_fill", fill_count_out, 0);
        chk("arst_addr", cache_addr_out, 0);
        tick(); tick();
        rst_in = 1'b0;

        // Full world load, value = addr[7:0].
        for (int i = 0; i < NB; i++) begin
            send(8'(i));
            if (i == 1000) rd_req_in = 2'b00;
        end
        chk("last_we", cache_we_out, 1);
        chk("last_addr", cache_addr_out, 16'hFFFF);
        chk("last_init0", initialized_out, 0);
        tick();
        chk("init_done", initialized_out, 1);
        chk("fill_wrap", fill_count_out, 0);
        tick();

        // Contention: both held four cycles.
        rd0_x_in = 6'd3; rd0_y_in = 6'd4; rd0_z_in = 4'd5;
        rd1_x_in = 6'd60; rd1_y_in = 6'd1; rd1_z_in = 4'd15;
        for (int k = 0; k < 8; k++) begin
            rd_req_in = (k < 4) ? 2'b11 : 2'b00;
            @(negedge clk_in);
            chk("rr_gnt", rd_grant_out, (k < 4) ? ((k % 2 == 0) ? 1 : 2) : 0);
            chk("rr_vld", rd_valid_out, (k >= 2 && k < 6) ? (((k - 2) % 2 == 0) ? 1 : 2) : 0);
            tick();
        end

        // Update packet then read back through requester 0.
        send(8'h12); tick(); send(8'h34); send(8'h07);
        chk("upd_we", cache_we_out, 1);
        chk("upd_addr", cache_addr_out, 16'h1234);
        chk("upd_data", cache_wdata_out, 8'h07);
        tick();
        rd0_x_in = 6'd52; rd0_y_in = 6'd8; rd0_z_in = 4'd1;
        rd_req_in = 2'b01;
        @(negedge clk_in);
        chk("upd_rd_gnt", rd_grant_out, 1);
        tick(); rd_req_in = 2'b00; tick();
        @(negedge clk_in);
        chk("upd_rd_vld", rd_valid_out, 1);
        chk("upd_rd_data", rd_data_out, 8'h07);
        tick();

        // Write priority: request raised in the write cycle waits one cycle.
        send(8'h00); send(8'h80); send(8'h5A);
        rd_req_in = 2'b01;
        @(negedge clk_in);
        chk("wp_gnt0", rd_grant_out, 0);
        chk("wp_we", cache_we_out, 1);
        tick();
        @(negedge clk_in);
        chk("wp_gnt1", rd_grant_out, 1);
        tick(); rd_req_in = 2'b00;

        // Randomized packets and held read requests.
        for (int c = 0; c < 3000; c++) begin
            for (int r = 0; r < 2; r++) begin
                if (rd_req_in[r] && g_prev[r]) rd_req_in[r] = 1'b0;
                else if (!rd_req_in[r] && $urandom_range(0, 2) == 0) begin
                    if (r == 0) begin
                        rd0_x_in = 6'($urandom); rd0_y_in = 6'($urandom); rd0_z_in = 4'($urandom);
                    end else begin
                        rd1_x_in = 6'($urandom); rd1_y_in = 6'($urandom); rd1_z_in = 4'($urandom);
                    end
                    rd_req_in[r] = 1'b1;
                end
            end
            uart_valid_in = ($urandom_range(0, 3) == 0);
            uart_data_in = 8'($urandom);
            tick();
        end
        uart_valid_in = 1'b0; rd_req_in = 2'b00;
        repeat (6) tick();

        // Reset with a read in flight: the response must be dropped.
        rd1_x_in = 6'd1; rd1_y_in = 6'd2; rd1_z_in = 4'd3;
        rd_req_in = 2'b10;
        @(negedge clk_in);
        chk("fl_gnt", rd_grant_out, 2);
        tick();
        rd_req_in = 2'b00;
        #2 rst_in = 1'b1;
        #1;
        chk("fl_vld", rd_valid_out, 0);
        chk("fl_init", initialized_out, 0);
        chk("fl_addr", cache_addr_out, 0);
        tick(); tick();
        rst_in = 1'b0;
        tick(); tick();
        send(8'hA5);
        chk("rl_we", cache_we_out, 1);
        chk("rl_addr", cache_addr_out, 0);
        chk("rl_data", cache_wdata_out, 8'hA5);
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
